// File: rtl/irrigation_timer_pkg.sv
// Shared types and helpers for the irrigation watering timer.
// State encoding, BCD limits and preset validation.
package irrigation_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic preset_ok(
    input logic [7:0] mn,
    input logic [7:0] sc
  );
    return (mn[7:4] <= BCD_MAX)
        && (mn[3:0] <= BCD_MAX)
        && (sc[7:4] <= SEC_TENS_MAX)
        && (sc[3:0] <= BCD_MAX);
  endfunction

endpackage

// File: rtl/irrigation_timer_ctrl_if.sv
// Front-panel command / status bundle of the watering timer.
// master = panel side, slave = timer controller side.
interface irrigation_timer_ctrl_if;

  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       load;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] min_bus;
  logic [7:0] sec_bus;
  logic       valve;
  logic       busy;
  logic       done;
  logic       preset_err;

  modport master (
    output preset_min, preset_sec,
    output load, start, pause, abort,
    input  min_bus, sec_bus,
    input  valve, busy, done, preset_err
  );

  modport slave (
    input  preset_min, preset_sec,
    input  load, start, pause, abort,
    output min_bus, sec_bus,
    output valve, busy, done, preset_err
  );

endinterface

// File: rtl/irrigation_timer_ctrl_bcd_down_digit.sv
// One BCD down-counting digit with parallel load.
// Wraps 0 -> MAX and flags a borrow to the next digit.
module bcd_down_digit
  import irrigation_timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);

  assign borrow_out = dec_en && (q == 4'd0);

  // digit register: load wins over decrement
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_val;
    end else if (dec_en) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/irrigation_timer_ctrl.sv
// Watering timer sequencer: BCD MM:SS countdown, valve drive.
// FSM and one-second prescaler; digits in bcd_down_digit.
module irrigation_timer_ctrl #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input logic                    clock,
  input logic                    reset,
  irrigation_timer_ctrl_if.slave bus
);

  import irrigation_timer_pkg::*;

  localparam int PW = (CLK_PER_SEC > 2)
                    ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_PER_SEC - 1);

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] presc;
  logic [3:0]    su;
  logic [3:0]    st;
  logic [3:0]    mu;
  logic [3:0]    mt;
  logic          b_su;
  logic          b_st;
  logic          b_mu;
  logic          unused_borrow;
  logic [15:0]   cnt;
  logic [15:0]   dig_val;
  logic          dig_load;
  logic          presc_clr;
  logic          run_en;
  logic          step;
  logic          done_n;
  logic          err_n;
  logic          do_abort;
  logic          do_load;
  logic          do_pause;
  logic          do_start;

  assign cnt = {mt, mu, st, su};

  assign do_abort = bus.abort;
  assign do_load  = bus.load && !bus.abort;
  assign do_pause = bus.pause && !bus.load
                 && !bus.abort;
  assign do_start = bus.start && !bus.pause
                 && !bus.load && !bus.abort;

  assign bus.min_bus = {mt, mu};
  assign bus.sec_bus = {st, su};

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // command decode, next state, digit and prescaler control
  always_comb begin
    state_n   = state;
    dig_load  = 1'b0;
    dig_val   = '0;
    presc_clr = 1'b0;
    run_en    = (state == ST_RUNNING);
    err_n     = 1'b0;
    done_n    = 1'b0;
    unique case (1'b1)
      do_abort: begin
        state_n   = ST_IDLE;
        dig_load  = 1'b1;
        presc_clr = 1'b1;
        run_en    = 1'b0;
      end
      do_load: begin
        if (state inside {ST_IDLE, ST_LOADED, ST_DONE}) begin
          if (preset_ok(bus.preset_min, bus.preset_sec)) begin
            state_n  = ST_LOADED;
            dig_load = 1'b1;
            dig_val  = {bus.preset_min, bus.preset_sec};
          end else begin
            err_n = 1'b1;
          end
        end
      end
      do_pause: begin
        if (state == ST_RUNNING) begin
          state_n = ST_PAUSED;
          run_en  = 1'b0;
        end
      end
      do_start: begin
        if (state == ST_LOADED && cnt != 16'h0000) begin
          state_n   = ST_RUNNING;
          presc_clr = 1'b1;
        end else if (state == ST_PAUSED) begin
          state_n = ST_RUNNING;
        end
      end
      default: ;
    endcase
    step = run_en && (presc == TC);
    if (step && cnt == 16'h0001) begin
      state_n = ST_DONE;
      done_n  = 1'b1;
    end
  end

  // one-second prescaler, frozen outside RUNNING
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if (run_en) begin
      presc <= (presc == TC) ? '0 : presc + PW'(1);
    end
  end

  // registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.valve      <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.preset_err <= 1'b0;
    end else begin
      bus.valve      <= (state_n == ST_RUNNING);
      bus.busy       <= (state_n inside {ST_RUNNING, ST_PAUSED});
      bus.done       <= done_n;
      bus.preset_err <= err_n;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX)) u_sec_units (
    .clock      (clock),
    .reset      (reset),
    .load       (dig_load),
    .load_val   (dig_val[3:0]),
    .dec_en     (step),
    .q          (su),
    .borrow_out (b_su)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (dig_load),
    .load_val   (dig_val[7:4]),
    .dec_en     (b_su),
    .q          (st),
    .borrow_out (b_st)
  );

  bcd_down_digit #(.MAX(BCD_MAX)) u_min_units (
    .clock      (clock),
    .reset      (reset),
    .load       (dig_load),
    .load_val   (dig_val[11:8]),
    .dec_en     (b_st),
    .q          (mu),
    .borrow_out (b_mu)
  );

  bcd_down_digit #(.MAX(BCD_MAX)) u_min_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (dig_load),
    .load_val   (dig_val[15:12]),
    .dec_en     (b_mu),
    .q          (mt),
    .borrow_out (unused_borrow)
  );

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Bench for irrigation_timer_ctrl: vector table, corner sequences,
// and random commands against a seconds-based reference model.
module tb_irrigation_timer_ctrl;

  localparam int CPS     = 4;
  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  irrigation_timer_ctrl_if bus();

  irrigation_timer_ctrl #(.CLK_PER_SEC(CPS)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ld;
    logic       st;
    logic       pa;
    logic       ab;
    logic [7:0] pm;
    logic [7:0] ps;
    logic [7:0] emin;
    logic [7:0] esec;
    logic       ev;
    logic       eb;
    logic       ed;
    logic       ee;
  } vec_t;

  vec_t vt[$];

  int   m_state;
  int   m_secs;
  int   m_pre;
  logic m_done;
  logic m_err;

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic legal(input logic [7:0] mn,
                                 input logic [7:0] sc);
    return bcd2i(mn) <= 99 && mn[3:0] < 10 && mn[7:4] < 10
        && sc[7:4] < 6 && sc[3:0] < 10;
  endfunction

  task automatic add(input logic ld, st, pa, ab,
                     input logic [7:0] pm, ps, emin, esec,
                     input logic ev, eb, ed, ee);
    vec_t v;
    v.ld = ld; v.st = st; v.pa = pa; v.ab = ab;
    v.pm = pm; v.ps = ps; v.emin = emin; v.esec = esec;
    v.ev = ev; v.eb = eb; v.ed = ed; v.ee = ee;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [7:0] emin, esec,
                         input logic ev, eb, ed, ee);
    chk({tag, ".min"},   32'(bus.min_bus),    32'(emin));
    chk({tag, ".sec"},   32'(bus.sec_bus),    32'(esec));
    chk({tag, ".valve"}, 32'(bus.valve),      32'(ev));
    chk({tag, ".busy"},  32'(bus.busy),       32'(eb));
    chk({tag, ".done"},  32'(bus.done),       32'(ed));
    chk({tag, ".err"},   32'(bus.preset_err), 32'(ee));
  endtask

  task automatic drive(input logic ld, st, pa, ab,
                       input logic [7:0] pm, ps);
    bus.load       = ld;
    bus.start      = st;
    bus.pause      = pa;
    bus.abort      = ab;
    bus.preset_min = pm;
    bus.preset_sec = ps;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_secs  = 0;
    m_pre   = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic ld, st, pa, ab,
                            input logic [7:0] pm, ps);
    logic counting;
    m_done   = 1'b0;
    m_err    = 1'b0;
    counting = (m_state == S_RUN);
    if (ab) begin
      m_state  = S_IDLE;
      m_secs   = 0;
      m_pre    = 0;
      counting = 1'b0;
    end else if (ld) begin
      if (m_state != S_RUN && m_state != S_PAUSE) begin
        if (legal(pm, ps)) begin
          m_secs  = bcd2i(pm) * 60 + bcd2i(ps);
          m_state = S_LOAD;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (pa) begin
      if (m_state == S_RUN) begin
        m_state  = S_PAUSE;
        counting = 1'b0;
      end
    end else if (st) begin
      if (m_state == S_LOAD && m_secs > 0) begin
        m_state = S_RUN;
        m_pre   = 0;
      end else if (m_state == S_PAUSE) begin
        m_state = S_RUN;
      end
    end
    if (counting) begin
      if (m_pre == CPS - 1) begin
        m_pre  = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_state = S_DONE;
          m_done  = 1'b1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
  endtask

  initial begin
    int done_at;
    bus.load       = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.abort      = 1'b0;
    bus.preset_min = 8'h00;
    bus.preset_sec = 8'h00;

    add(1, 0, 0, 0, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h60, 8'h00, 8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 0, 8'h1A, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1);
    add(1, 0, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h5A, 8'h01, 8'h00, 0, 0, 0, 1);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 1, 0, 0);
    add(1, 1, 0, 1, 8'h00, 8'h07, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 8'h99, 8'h59, 8'h99, 8'h59, 0, 0, 0, 0);
    add(0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].ld, vt[i].st, vt[i].pa, vt[i].ab,
            vt[i].pm, vt[i].ps);
      chk_all($sformatf("vec%0d", i), vt[i].emin, vt[i].esec,
              vt[i].ev, vt[i].eb, vt[i].ed, vt[i].ee);
    end

    drive(1, 0, 0, 0, 8'h01, 8'h00);
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    done_at = 0;
    for (int k = 1; k <= 300; k++) begin
      idle();
      if (bus.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    chk("minute.done_at", 32'(done_at), 32'd240);
    chk_all("minute.end", 8'h00, 8'h00, 0, 0, 1, 0);
    idle();
    chk_all("minute.after", 8'h00, 8'h00, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 8'h00, 8'h05);
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    chk_all("pz.start", 8'h00, 8'h05, 1, 1, 0, 0);
    idle();
    idle();
    drive(0, 0, 1, 0, 8'h00, 8'h00);
    chk_all("pz.pause", 8'h00, 8'h05, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk($sformatf("pz.hold%0d.sec", i), 32'(bus.sec_bus), 32'h05);
      chk($sformatf("pz.hold%0d.valve", i), 32'(bus.valve), 32'd0);
    end
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    chk_all("pz.resume", 8'h00, 8'h05, 1, 1, 0, 0);
    idle();
    chk_all("pz.r1", 8'h00, 8'h05, 1, 1, 0, 0);
    idle();
    chk_all("pz.r2", 8'h00, 8'h04, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 8'h00, 8'h00);
    chk_all("pz.abort", 8'h00, 8'h00, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 8'h00, 8'h03);
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    repeat (4) idle();
    chk_all("rm.at02", 8'h00, 8'h02, 1, 1, 0, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rm.async", 8'h00, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("rm.hold%0d", i), 8'h00, 8'h00, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 8'h00, 8'h00);
    chk_all("rm.start", 8'h00, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk($sformatf("rm.quiet%0d", i), 32'({bus.done, bus.valve}), 32'd0);
    end

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      int         r;
      logic       ld;
      logic       st;
      logic       pa;
      logic       ab;
      logic [7:0] pm;
      logic [7:0] ps;
      r  = int'($urandom_range(0, 99));
      ab = (r < 1);
      ld = (r >= 1 && r < 6);
      pa = (r >= 6 && r < 10);
      st = (r >= 10 && r < 18);
      if ($urandom_range(0, 4) == 0) begin
        pm = 8'($urandom);
        ps = 8'($urandom);
      end else begin
        pm = i2bcd(int'($urandom_range(0, 1)));
        ps = i2bcd(int'($urandom_range(0, 12)));
      end
      drive(ld, st, pa, ab, pm, ps);
      model_step(ld, st, pa, ab, pm, ps);
      chk_all($sformatf("rnd%0d", n),
              i2bcd(m_secs / 60), i2bcd(m_secs % 60),
              m_state == S_RUN,
              m_state == S_RUN || m_state == S_PAUSE,
              m_done, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
